uart_transmitter: RTL

Serial transmit half of the UART link: accepts 8-bit words over a valid/ready handshake and emits frames that the existing UART receiver decodes. Each frame is a start bit, 8 data bits LSB first, an odd-parity bit and one stop bit. A one-word holding register lets the next frame start directly after the current stop bit. The block sits between the system data source and the serial line.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_bit_timer.sv | 18 +
 rtl/uart_transmitter.sv | 81 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 11;
  localparam int DEFAULT_CLKS_PER_BIT = 40;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts clocks within one serial bit period and flags its last clock
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  logic [CNT_W-1:0] clk_cnt;
  assign bit_end = (clk_cnt == LAST);
  // clock counter wraps at each bit end so consecutive bits never drift
  always_ff @(posedge clk)
    if (!reset || restart) clk_cnt <= '0;
    else clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N-odd/even-parity-1 UART transmitter with a one-word holding register
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);
  uart_state_e state, state_n;
  logic [UART_DATA_W-1:0] hold_data, shift, shift_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic hold_full, par, par_n, load, bit_end, tx_n;
  assign tx_ready = ~hold_full;
  assign busy = (state != IDLE);
  assign done = (state == STOP) && bit_end;
  // the counter sits at 0 in IDLE; all other state changes land on a bit end where it wraps anyway
  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (state == IDLE),
    .bit_end (bit_end)
  );
  // next-state logic; the line level is derived from the next state so tx is a true register
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_idx_n = bit_idx;
    par_n = par;
    load = 1'b0;
    case (state)
      IDLE:   if (hold_full) begin load = 1'b1; state_n = START; end
      START:  if (bit_end) begin state_n = DATA; bit_idx_n = '0; end
      DATA:   if (bit_end) begin
                shift_n = shift >> 1;
                bit_idx_n = bit_idx + 3'd1;
                state_n = (bit_idx == 3'd7) ? PARITY : DATA;
              end
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end) begin load = hold_full; state_n = hold_full ? START : IDLE; end
      default: state_n = IDLE;
    endcase
    shift_n = load ? hold_data : shift_n;
    par_n = load ? (PARITY_ODD ? ~^hold_data : ^hold_data) : par_n;
    tx_n = (state_n == START) ? 1'b0 :
           (state_n == DATA)  ? shift_n[0] :
           (state_n == PARITY) ? par_n : 1'b1;
  end
  // FSM, shift register and line register
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      bit_idx <= '0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_idx <= bit_idx_n;
      par <= par_n;
      tx <= tx_n;
    end
  // holding register: a load only happens while full, so it never coincides with an accept
  always_ff @(posedge clk)
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) hold_full <= 1'b0;
    else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
endmodule
